// File: rtl/conv_mac_scheduler_pkg.sv
// Shared types and defaults for the convolution MAC scheduler slice.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_IMG_H = 28;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_K     = 5;

  // Width needed to address n distinct values, never narrower than one bit.
  function automatic int addrWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac_scheduler_if.sv
// Tap-operation stream and writeback return between scheduler and MAC datapath.
interface conv_mac_scheduler_if
  import cnn_pkg::*;
#(
  parameter int IMG_H = DEF_IMG_H,
  parameter int IMG_W = DEF_IMG_W,
  parameter int K     = DEF_K
);
  localparam int IAW = addrWidth(IMG_H * IMG_W);
  localparam int WAW = addrWidth(K * K);
  localparam int OAW = addrWidth((IMG_H - K + 1) * (IMG_W - K + 1));

  logic           op_valid;
  logic           op_ready;
  logic [IAW-1:0] img_addr;
  logic [WAW-1:0] wgt_addr;
  logic [OAW-1:0] out_addr;
  logic           op_first;
  logic           op_last;
  logic           res_valid;

  modport master (
    output op_valid, img_addr, wgt_addr, out_addr, op_first, op_last,
    input  op_ready, res_valid
  );

  modport slave (
    input  op_valid, img_addr, wgt_addr, out_addr, op_first, op_last,
    output op_ready, res_valid
  );

endinterface

// File: rtl/conv_mac_scheduler_tap_counter.sv
// Nested kx/ky/ox/oy walk over the convolution (kx fastest) with derived addresses.
module conv_tap_counter
  import cnn_pkg::*;
#(
  parameter int IMG_H = DEF_IMG_H,
  parameter int IMG_W = DEF_IMG_W,
  parameter int K     = DEF_K
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         i_clear,
  input  logic                                         i_advance,
  output logic [addrWidth(IMG_H*IMG_W)-1:0]             o_img_addr,
  output logic [addrWidth(K*K)-1:0]                     o_wgt_addr,
  output logic [addrWidth((IMG_H-K+1)*(IMG_W-K+1))-1:0] o_out_addr,
  output logic                                         o_first,
  output logic                                         o_last,
  output logic                                         o_final
);
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int IAW   = addrWidth(IMG_H * IMG_W);
  localparam int WAW   = addrWidth(K * K);
  localparam int OAW   = addrWidth(OUT_H * OUT_W);
  localparam int KW    = addrWidth(K);
  localparam int XW    = addrWidth(OUT_W);
  localparam int YW    = addrWidth(OUT_H);

  logic [KW-1:0] r_kx, r_ky;
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic          w_kxWrap, w_kyWrap, w_oxWrap, w_oyWrap;

  assign w_kxWrap = (r_kx == KW'(K - 1));
  assign w_kyWrap = (r_ky == KW'(K - 1));
  assign w_oxWrap = (r_ox == XW'(OUT_W - 1));
  assign w_oyWrap = (r_oy == YW'(OUT_H - 1));

  // Each inner counter carries into the next only when it wraps.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_advance) begin
      if (!w_kxWrap) begin
        r_kx <= r_kx + 1'b1;
      end else begin
        r_kx <= '0;
        if (!w_kyWrap) begin
          r_ky <= r_ky + 1'b1;
        end else begin
          r_ky <= '0;
          if (!w_oxWrap) begin
            r_ox <= r_ox + 1'b1;
          end else begin
            r_ox <= '0;
            r_oy <= w_oyWrap ? '0 : r_oy + 1'b1;
          end
        end
      end
    end
  end

  assign o_img_addr = (IAW'(r_oy) + IAW'(r_ky)) * IAW'(IMG_W) + IAW'(r_ox) + IAW'(r_kx);
  assign o_wgt_addr = WAW'(r_ky) * WAW'(K) + WAW'(r_kx);
  assign o_out_addr = OAW'(r_oy) * OAW'(OUT_W) + OAW'(r_ox);
  assign o_first    = (r_kx == '0) && (r_ky == '0);
  assign o_last     = w_kxWrap && w_kyWrap;
  assign o_final    = o_last && w_oxWrap && w_oyWrap;

endmodule

// File: rtl/conv_mac_scheduler.sv
// Convolution MAC scheduler: FSM plus writeback credit tracking around conv_tap_counter.
// Optional stall performance counters are enabled with `define CONV_SCHED_PERF_EN.
module conv_mac_scheduler
  import cnn_pkg::*;
#(
  parameter int IMG_H           = DEF_IMG_H,
  parameter int IMG_W           = DEF_IMG_W,
  parameter int K               = DEF_K,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  conv_mac_scheduler_if.master bus
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]         o_stall_cycles,
  output logic [31:0]         o_credit_stall_cycles
`endif
);
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int TOTAL = OUT_H * OUT_W;
  localparam int OSW   = addrWidth(MAX_OUTSTANDING + 1);
  localparam int RW    = addrWidth(TOTAL + 1);

  sched_state_t r_state, w_nextState;
  logic [OSW-1:0] r_outstanding;
  logic [RW-1:0]  r_retired;
  logic w_first, w_last, w_final;
  logic w_creditGate, w_opValid, w_handshake, w_startAccept, w_resAccept, w_issueLast;

  conv_tap_counter #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K(K)) u_taps (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_startAccept),
    .i_advance  (w_handshake),
    .o_img_addr (bus.img_addr),
    .o_wgt_addr (bus.wgt_addr),
    .o_out_addr (bus.out_addr),
    .o_first    (w_first),
    .o_last     (w_last),
    .o_final    (w_final)
  );

  // Credit is only checked on a pixel's first tap so a pixel's taps stay contiguous.
  assign w_creditGate  = (r_state == ISSUE) && w_first && (r_outstanding >= OSW'(MAX_OUTSTANDING));
  assign w_opValid     = (r_state == ISSUE) && !w_creditGate;
  assign w_handshake   = w_opValid && bus.op_ready;
  assign w_issueLast   = w_handshake && w_last;
  assign w_startAccept = (r_state == IDLE) && i_start;
  assign w_resAccept   = bus.res_valid && ((r_state == ISSUE) || (r_state == DRAIN))
                         && (r_outstanding != '0);

  assign bus.op_valid = w_opValid;
  assign bus.op_first = w_first;
  assign bus.op_last  = w_last;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE:  if (w_startAccept) w_nextState = ISSUE;
      ISSUE: begin
        o_busy = 1'b1;
        if (w_handshake && w_final) w_nextState = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (r_retired == RW'(TOTAL)) w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || w_startAccept) begin
      r_outstanding <= '0;
      r_retired     <= '0;
    end else begin
      case ({w_issueLast, w_resAccept})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_resAccept) r_retired <= r_retired + 1'b1;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_stallCycles, r_creditStallCycles;

  always_ff @(posedge clk) begin
    if (reset || w_startAccept) begin
      r_stallCycles       <= '0;
      r_creditStallCycles <= '0;
    end else begin
      if (w_opValid && !bus.op_ready) r_stallCycles <= r_stallCycles + 1'b1;
      if (w_creditGate)               r_creditStallCycles <= r_creditStallCycles + 1'b1;
    end
  end

  assign o_stall_cycles        = r_stallCycles;
  assign o_credit_stall_cycles = r_creditStallCycles;
`endif

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Directed testbench for conv_mac_scheduler (28x28 image, 5x5 kernel, 2 credits).
module tb_conv_mac_scheduler;

  logic clk;
  logic reset;
  logic i_start;
  logic o_busy;
  logic o_done;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] o_stall_cycles, o_credit_stall_cycles;
`endif

  int vectors     = 0;
  int miscompares = 0;

  conv_mac_scheduler_if ifc ();

  conv_mac_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .bus     (ifc)
`ifdef CONV_SCHED_PERF_EN
    ,
    .o_stall_cycles        (o_stall_cycles),
    .o_credit_stall_cycles (o_credit_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent runPass call
  int opCount, seqErr, stallErr, busyErr, doneCount;
  logic [31:0] op0Img, op0Wgt, op0First, op24Img, op24Wgt, op24Last;
  logic [31:0] op25Img, op25Out, lastImg, lastOut;

  task automatic applyStimulus(input logic rdy, input logic res, input logic st);
    ifc.op_ready  = rdy;
    ifc.res_valid = res;
    i_start       = st;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Walks one pass against an independent kx/ky/ox/oy model; res_valid returns
  // two cycles after every op_last handshake. readyMode 0: always ready,
  // 1: random 50%, 2: ready low for cycles 300..309 only.
  task automatic runPass(input int readyMode, input int limit, input int stopOps,
                         input int startAt);
    int mkx, mky, mox, moy, expImg, expWgt, expOut;
    int resDue[$];
    bit rdy, res, st, prevStall, sawDone;
    logic [31:0] pImg, pWgt, pOut, pFirst, pLast;
    mkx = 0; mky = 0; mox = 0; moy = 0;
    opCount = 0; seqErr = 0; stallErr = 0; busyErr = 0; doneCount = 0;
    prevStall = 0; sawDone = 0;
    pImg = 0; pWgt = 0; pOut = 0; pFirst = 0; pLast = 0;
    for (int t = 0; t < limit; t++) begin
      if (stopOps >= 0 && opCount == stopOps) break;
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(t >= 300 && t < 310);
      endcase
      res = 1'b0;
      if (resDue.size() > 0 && resDue[0] == t) begin
        res = 1'b1;
        void'(resDue.pop_front());
      end
      sawDone = (o_done === 1'b1);
      st = (t == startAt) || sawDone;
      applyStimulus(rdy, res, st);
      if (sawDone) doneCount++;
      else if (o_busy !== 1'b1) busyErr++;
      if (prevStall && (ifc.op_valid !== 1'b1 || 32'(ifc.img_addr) !== pImg ||
          32'(ifc.wgt_addr) !== pWgt || 32'(ifc.out_addr) !== pOut ||
          32'(ifc.op_first) !== pFirst || 32'(ifc.op_last) !== pLast))
        stallErr++;
      if (ifc.op_valid === 1'b1 && rdy) begin
        expImg = (moy + mky) * 28 + mox + mkx;
        expWgt = mky * 5 + mkx;
        expOut = moy * 24 + mox;
        if (32'(ifc.img_addr) !== expImg || 32'(ifc.wgt_addr) !== expWgt ||
            32'(ifc.out_addr) !== expOut || ifc.op_first !== (mkx == 0 && mky == 0) ||
            ifc.op_last !== (mkx == 4 && mky == 4))
          seqErr++;
        if (opCount == 0) begin
          op0Img = 32'(ifc.img_addr); op0Wgt = 32'(ifc.wgt_addr); op0First = 32'(ifc.op_first);
        end
        if (opCount == 24) begin
          op24Img = 32'(ifc.img_addr); op24Wgt = 32'(ifc.wgt_addr); op24Last = 32'(ifc.op_last);
        end
        if (opCount == 25) begin
          op25Img = 32'(ifc.img_addr); op25Out = 32'(ifc.out_addr);
        end
        lastImg = 32'(ifc.img_addr);
        lastOut = 32'(ifc.out_addr);
        if (ifc.op_last === 1'b1) resDue.push_back(t + 2);
        if (mkx < 4) mkx++;
        else begin
          mkx = 0;
          if (mky < 4) mky++;
          else begin
            mky = 0;
            if (mox < 23) mox++;
            else begin
              mox = 0;
              moy = (moy < 23) ? moy + 1 : 0;
            end
          end
        end
        opCount++;
      end
      prevStall = (ifc.op_valid === 1'b1) && !rdy;
      pImg = 32'(ifc.img_addr); pWgt = 32'(ifc.wgt_addr); pOut = 32'(ifc.out_addr);
      pFirst = 32'(ifc.op_first); pLast = 32'(ifc.op_last);
      @(negedge clk);
      if (sawDone) break;
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int extraDone;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_op_valid", ifc.op_valid, 0);
    reset = 1'b0;

    $display("[TB] res_valid in IDLE");
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_res_busy", o_busy, 0);
    checkOutput("idle_res_valid", ifc.op_valid, 0);

    $display("[TB] full pass, always ready, start pulsed mid-issue and in DONE");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    runPass(0, 15000, -1, 100);
    checkOutput("p1_op_count", opCount, 14400);
    checkOutput("p1_seq_errors", seqErr, 0);
    checkOutput("p1_busy_errors", busyErr, 0);
    checkOutput("p1_done_count", doneCount, 1);
    checkOutput("p1_op0_img", op0Img, 0);
    checkOutput("p1_op0_wgt", op0Wgt, 0);
    checkOutput("p1_op0_first", op0First, 1);
    checkOutput("p1_op24_img", op24Img, 116);
    checkOutput("p1_op24_wgt", op24Wgt, 24);
    checkOutput("p1_op24_last", op24Last, 1);
    checkOutput("p1_op25_img", op25Img, 1);
    checkOutput("p1_op25_out", op25Out, 1);
    checkOutput("p1_final_img", lastImg, 783);
    checkOutput("p1_final_out", lastOut, 575);
    checkOutput("p1_after_done", o_done, 0);
    checkOutput("p1_after_busy", o_busy, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutput("p1_no_restart_busy", o_busy, 0);
    checkOutput("p1_no_restart_valid", ifc.op_valid, 0);

    $display("[TB] full pass, random backpressure");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    runPass(1, 40000, -1, -1);
    checkOutput("p2_op_count", opCount, 14400);
    checkOutput("p2_seq_errors", seqErr, 0);
    checkOutput("p2_stall_stability", stallErr, 0);
    checkOutput("p2_done_count", doneCount, 1);

    $display("[TB] credit limit with withheld writebacks");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 1; i < 25; i++) begin applyStimulus(1'b1, 1'b0, 1'b0); @(negedge clk); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("credit_pix1_valid", ifc.op_valid, 1);
    checkOutput("credit_pix1_out", 32'(ifc.out_addr), 1);
    @(negedge clk);
    for (int i = 26; i < 50; i++) begin applyStimulus(1'b1, 1'b0, 1'b0); @(negedge clk); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("credit_gate_valid", ifc.op_valid, 0);
    checkOutput("credit_gate_out", 32'(ifc.out_addr), 2);
    checkOutput("credit_gate_first", ifc.op_first, 1);
    checkOutput("credit_gate_busy", o_busy, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin applyStimulus(1'b1, 1'b0, 1'b0); @(negedge clk); end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("credit_release_cycle_valid", ifc.op_valid, 0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("credit_resume_valid", ifc.op_valid, 1);
    checkOutput("credit_resume_img", 32'(ifc.img_addr), 2);
    @(negedge clk);
    for (int i = 1; i < 24; i++) begin applyStimulus(1'b1, 1'b0, 1'b0); @(negedge clk); end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("credit_coincide_last", ifc.op_last, 1);
    checkOutput("credit_coincide_valid", ifc.op_valid, 1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("credit_pix3_valid", ifc.op_valid, 1);
    checkOutput("credit_pix3_out", 32'(ifc.out_addr), 3);
    @(negedge clk);
    for (int i = 1; i < 25; i++) begin applyStimulus(1'b1, 1'b0, 1'b0); @(negedge clk); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("credit_pix4_valid", ifc.op_valid, 0);
    checkOutput("credit_pix4_out", 32'(ifc.out_addr), 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset at op 5000 and replay");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    runPass(0, 6000, 5000, -1);
    checkOutput("abort_op_count", opCount, 5000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_valid", ifc.op_valid, 0);
    extraDone = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_done === 1'b1) extraDone++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", extraDone, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("replay_valid", ifc.op_valid, 1);
    checkOutput("replay_img", 32'(ifc.img_addr), 0);
    checkOutput("replay_wgt", 32'(ifc.wgt_addr), 0);
    checkOutput("replay_out", 32'(ifc.out_addr), 0);
    checkOutput("replay_first", ifc.op_first, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

`ifdef CONV_SCHED_PERF_EN
    $display("[TB] stall counters with ten cycles of backpressure");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    runPass(2, 15000, -1, -1);
    checkOutput("perf_done_count", doneCount, 1);
    checkOutput("perf_stall_cycles", o_stall_cycles, 10);
    checkOutput("perf_credit_stall_cycles", o_credit_stall_cycles, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
